// File: rtl/bnn_mem_pkg.sv
// Shared types and default sizes for the binarized-network bit memory responder.
package bnn_mem_pkg;

    localparam int DEFAULT_DEPTH  = 1024;
    localparam int DEFAULT_WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RMW_WB = 2'd1,
        CLEAR  = 2'd2
    } state_e;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_e;

endpackage

// File: rtl/bnn_rr_arb2.sv
// Two-requester round-robin arbiter; the last-grant register only moves when a grant is taken.
module bnn_rr_arb2
    import bnn_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic rd_req_i,
    input  logic wr_req_i,
    input  logic take_i,
    output logic rd_gnt_o,
    output logic wr_gnt_o
);

    req_e last_q;
    req_e last_d;

    always_comb begin
        rd_gnt_o = 1'b0;
        wr_gnt_o = 1'b0;
        if (en_i) begin
            if (rd_req_i && wr_req_i) begin
                // Contention: favour whichever side was not served last.
                rd_gnt_o = (last_q == WRITE);
                wr_gnt_o = (last_q == READ);
            end else begin
                rd_gnt_o = rd_req_i;
                wr_gnt_o = wr_req_i;
            end
        end
        last_d = last_q;
        if (take_i) begin
            last_d = rd_gnt_o ? READ : WRITE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= READ;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/bnn_bit_mem_responder.sv
// Bit-addressed packed memory with 1-cycle reads, 2-cycle RMW writes and a bulk clear.
// Optional word parity is enabled by defining BNN_MEM_PARITY_EN.
module bnn_bit_mem_responder
    import bnn_mem_pkg::*;
#(
    parameter  int DEPTH  = DEFAULT_DEPTH,
    parameter  int WORD_W = DEFAULT_WORD_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_rsp_valid,
    output logic              rd_data,
    output logic              rd_err,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_data,
    input  logic              par_inject,
    input  logic              clr_start,
    output logic              busy,
    output logic              clr_done
);

    localparam int BIT_W     = $clog2(WORD_W);
    localparam int NUM_WORDS = DEPTH / WORD_W;
    localparam int WIDX_W    = ADDR_W - BIT_W;
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NUM_WORDS - 1);

    state_e            state_q;
    logic [WIDX_W-1:0] clr_ptr_q;
    logic [WIDX_W-1:0] rmw_idx_q;
    logic [WORD_W-1:0] rmw_buf_q;
    logic              rd_rsp_valid_q;
    logic              rd_data_q;
    logic              rd_err_q;
    logic              clr_done_q;

    logic [WORD_W-1:0] mem_q [NUM_WORDS];

    logic [WIDX_W-1:0] rd_widx, wr_widx;
    logic [BIT_W-1:0]  rd_bidx, wr_bidx;
    logic [WORD_W-1:0] rd_word, wr_word_d;
    logic              rd_err_d;
    logic              arb_en, rd_acc, wr_acc;

    assign rd_widx = rd_addr[ADDR_W-1:BIT_W];
    assign rd_bidx = rd_addr[BIT_W-1:0];
    assign wr_widx = wr_addr[ADDR_W-1:BIT_W];
    assign wr_bidx = wr_addr[BIT_W-1:0];
    assign rd_word = mem_q[rd_widx];

    always_comb begin
        wr_word_d          = mem_q[wr_widx];
        wr_word_d[wr_bidx] = wr_data;
    end

    assign arb_en = (state_q == IDLE) && !clr_start;
    assign rd_acc = rd_valid && rd_ready;
    assign wr_acc = wr_valid && wr_ready;

    bnn_rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .en_i     (arb_en),
        .rd_req_i (rd_valid),
        .wr_req_i (wr_valid),
        .take_i   (rd_acc || wr_acc),
        .rd_gnt_o (rd_ready),
        .wr_gnt_o (wr_ready)
    );

`ifdef BNN_MEM_PARITY_EN
    logic par_mem_q [NUM_WORDS];
    logic rmw_par_q;

    assign rd_err_d = ^{rd_word, par_mem_q[rd_widx]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rmw_par_q <= 1'b0;
        end else if (wr_acc) begin
            rmw_par_q <= (^wr_word_d) ^ par_inject;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == RMW_WB) begin
            par_mem_q[rmw_idx_q] <= rmw_par_q;
        end else if (state_q == CLEAR) begin
            par_mem_q[clr_ptr_q] <= 1'b0;
        end
    end
`else
    logic par_inject_unused;

    assign par_inject_unused = par_inject;
    assign rd_err_d          = 1'b0;
`endif

    // Storage carries no reset; only the clear engine defines its contents.
    always_ff @(posedge clk) begin
        if (state_q == RMW_WB) begin
            mem_q[rmw_idx_q] <= rmw_buf_q;
        end else if (state_q == CLEAR) begin
            mem_q[clr_ptr_q] <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            clr_ptr_q      <= '0;
            rmw_idx_q      <= '0;
            rmw_buf_q      <= '0;
            rd_rsp_valid_q <= 1'b0;
            rd_data_q      <= 1'b0;
            rd_err_q       <= 1'b0;
            clr_done_q     <= 1'b0;
        end else begin
            rd_rsp_valid_q <= 1'b0;
            clr_done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_start) begin
                        state_q   <= CLEAR;
                        clr_ptr_q <= '0;
                    end else if (rd_acc) begin
                        rd_rsp_valid_q <= 1'b1;
                        rd_data_q      <= rd_word[rd_bidx];
                        rd_err_q       <= rd_err_d;
                    end else if (wr_acc) begin
                        rmw_idx_q <= wr_widx;
                        rmw_buf_q <= wr_word_d;
                        state_q   <= RMW_WB;
                    end
                end
                RMW_WB: begin
                    state_q <= IDLE;
                end
                CLEAR: begin
                    if (clr_ptr_q == LAST_WORD) begin
                        state_q    <= IDLE;
                        clr_ptr_q  <= '0;
                        clr_done_q <= 1'b1;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + WIDX_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rd_rsp_valid = rd_rsp_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_err       = rd_err_q;
    assign clr_done     = clr_done_q;
    assign busy         = (state_q == RMW_WB) || (state_q == CLEAR);

endmodule

// File: tb/tb_bnn_bit_mem_responder.sv
// Scoreboard bench for bnn_bit_mem_responder: bit-level reference model, directed scenarios, random traffic.
module tb_bnn_bit_mem_responder;

    localparam int DEPTH  = 1024;
    localparam int WORD_W = 32;
    localparam int A      = 10;
    localparam int BW     = 5;
    localparam int NW     = DEPTH / WORD_W;

    logic         clk = 1'b0;
    logic         rst;
    logic         rd_valid, rd_ready, rd_rsp_valid, rd_data, rd_err;
    logic [A-1:0] rd_addr, wr_addr;
    logic         wr_valid, wr_ready, wr_data, par_inject;
    logic         clr_start, busy, clr_done;

    always #5 clk = ~clk;

    bnn_bit_mem_responder #(.DEPTH(DEPTH), .WORD_W(WORD_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_addr      (rd_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_data      (rd_data),
        .rd_err       (rd_err),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .par_inject   (par_inject),
        .clr_start    (clr_start),
        .busy         (busy),
        .clr_done     (clr_done)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: one entry per stored bit, plus a per-word "parity corrupted" flag.
    logic model_bit [DEPTH];
    logic model_err [NW];

    typedef struct {
        logic [A-1:0] addr;
        logic         data;
        logic         err;
    } rsp_t;
    rsp_t rsp_q[$];

    int phase = 0;          // 0 idle, 1 write-back, 2 clearing
    int clr_cnt = 0;
    bit done_pending = 0;
    bit last_wr = 0;        // last granted requester was the writer
    bit rd_prev = 0;
    bit acc_rd = 0;
    bit acc_wr = 0;

    function automatic void chk(string name, logic act, logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic exp_err(logic [A-1:0] a);
`ifdef BNN_MEM_PARITY_EN
        return model_err[a[A-1:BW]];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [A-1:0] rand_addr();
        if ($urandom % 2 == 0) return A'($urandom_range(0, 127));
        return A'($urandom_range(0, DEPTH - 1));
    endfunction

    // One clock cycle: judge the handshakes against the model, then advance.
    task automatic step();
        bit exp_rg, exp_wg, exp_done, exp_rsp;
        @(negedge clk);
        exp_done = done_pending;
        done_pending = 0;
        exp_rsp = rd_prev;
        rd_prev = 0;
        chk("clr_done", clr_done, exp_done);
        chk("rd_rsp_valid", rd_rsp_valid, exp_rsp);
        acc_rd = 0;
        acc_wr = 0;
        exp_rg = 0;
        exp_wg = 0;
        case (phase)
            0: begin
                chk("busy_idle", busy, 1'b0);
                if (clr_start) begin
                    phase = 2;
                    clr_cnt = 0;
                    for (int i = 0; i < DEPTH; i++) model_bit[i] = 1'b0;
                    for (int i = 0; i < NW; i++) model_err[i] = 1'b0;
                    $display("[TB] clear start");
                end else if (rd_valid && wr_valid) begin
                    if (last_wr) exp_rg = 1;
                    else exp_wg = 1;
                end else begin
                    exp_rg = rd_valid;
                    exp_wg = wr_valid;
                end
                chk("rd_ready", rd_ready, exp_rg);
                chk("wr_ready", wr_ready, exp_wg);
                if (exp_rg) begin
                    acc_rd = 1;
                    last_wr = 0;
                    rd_prev = 1;
                    rsp_q.push_back('{rd_addr, model_bit[rd_addr], exp_err(rd_addr)});
                end
                if (exp_wg) begin
                    acc_wr = 1;
                    last_wr = 1;
                    model_bit[wr_addr] = wr_data;
                    model_err[wr_addr[A-1:BW]] = par_inject;
                    phase = 1;
                    $display("[TB] write addr=%0d data=%b inject=%b", wr_addr, wr_data, par_inject);
                end
            end
            1: begin
                chk("busy_wb", busy, 1'b1);
                chk("rd_ready_wb", rd_ready, 1'b0);
                chk("wr_ready_wb", wr_ready, 1'b0);
                phase = 0;
            end
            default: begin
                chk("busy_clear", busy, 1'b1);
                chk("rd_ready_clear", rd_ready, 1'b0);
                chk("wr_ready_clear", wr_ready, 1'b0);
                clr_cnt++;
                if (clr_cnt == NW) begin
                    phase = 0;
                    done_pending = 1;
                end
            end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    // Present requests and hold them until accepted.
    task automatic issue(input bit rv, input logic [A-1:0] ra, input bit wv,
                         input logic [A-1:0] wa, input bit wd, input bit inj);
        rd_valid = rv;
        rd_addr = ra;
        wr_valid = wv;
        wr_addr = wa;
        wr_data = wd;
        par_inject = inj;
        for (int n = 0; n < 100 && (rd_valid || wr_valid); n++) begin
            step();
            if (acc_rd) rd_valid = 0;
            if (acc_wr) wr_valid = 0;
        end
        if (rd_valid || wr_valid) begin
            tests++;
            fails++;
            $display("FAIL issue_timeout: got no accept within 100 cycles, required accept");
            rd_valid = 0;
            wr_valid = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk);
        chk("rst_rd_rsp_valid", rd_rsp_valid, 1'b0);
        chk("rst_rd_data", rd_data, 1'b0);
        chk("rst_rd_err", rd_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_clr_done", clr_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 0;
        phase = 0;
        last_wr = 0;
        done_pending = 0;
        rd_prev = 0;
    endtask

    // Monitor: every read response is matched to the oldest expected entry.
    always @(negedge clk) begin
        rsp_t r;
        if (!rst && rd_rsp_valid) begin
            if (rsp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got rd_rsp_valid=1 expected no response");
            end else begin
                r = rsp_q.pop_front();
                chk("rd_data", rd_data, r.data);
                chk("rd_err", rd_err, r.err);
                $display("[TB] read addr=%0d data=%b err=%b exp=%b/%b", r.addr, rd_data, rd_err, r.data, r.err);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1;
        rd_valid = 0;
        rd_addr = '0;
        wr_valid = 0;
        wr_addr = '0;
        wr_data = 0;
        par_inject = 0;
        clr_start = 0;
        do_reset();

        // Clear, then read boundary addresses.
        clr_start = 1;
        step();
        clr_start = 0;
        idle(NW + 1);
        issue(1, A'(0), 0, '0, 0, 0);
        issue(1, A'(511), 0, '0, 0, 0);
        issue(1, A'(1023), 0, '0, 0, 0);

        // Write/readback with neighbours in the same word.
        issue(0, '0, 1, A'(37), 1, 0);
        issue(1, A'(37), 0, '0, 0, 0);
        issue(1, A'(36), 0, '0, 0, 0);
        issue(1, A'(38), 0, '0, 0, 0);
        idle(2);

        // Read of a bit held behind a write to the same bit.
        issue(1, A'(100), 1, A'(100), 1, 0);
        idle(2);

        // Clear pulse during write-back must be dropped.
        issue(0, '0, 1, A'(200), 1, 0);
        clr_start = 1;
        step();
        clr_start = 0;
        idle(NW + 4);

        // Parity injection.
        issue(0, '0, 1, A'(5), 1, 1);
        issue(1, A'(5), 0, '0, 0, 0);
        issue(1, A'(40), 0, '0, 0, 0);
        idle(2);

        // Continuous contention straight after reset.
        do_reset();
        rd_valid = 1;
        rd_addr = A'(37);
        wr_valid = 1;
        wr_addr = A'(300);
        wr_data = 1;
        par_inject = 0;
        repeat (12) begin
            step();
            if (acc_rd) rd_addr = rand_addr();
            if (acc_wr) begin
                wr_addr = rand_addr();
                wr_data = 1'($urandom);
            end
        end
        rd_valid = 0;
        wr_valid = 0;
        idle(3);

        // Random traffic with occasional clears.
        for (int n = 0; n < 1500; n++) begin
            if (!rd_valid && ($urandom % 2 == 0)) begin
                rd_valid = 1;
                rd_addr = rand_addr();
            end
            if (!wr_valid && ($urandom % 3 == 0)) begin
                wr_valid = 1;
                wr_addr = rand_addr();
                wr_data = 1'($urandom);
                par_inject = ($urandom % 8 == 0);
            end
            clr_start = ($urandom % 200 == 0);
            step();
            clr_start = 0;
            if (acc_rd) rd_valid = 0;
            if (acc_wr) wr_valid = 0;
        end
        rd_valid = 0;
        wr_valid = 0;
        idle(NW + 4);

        tests++;
        if (rsp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_rsp: got %0d outstanding responses, required 0", rsp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
